stdout_host_reader: RTL

STDOUT_HOST_READER -- requirements
Module: stdout_host_reader

---
 rtl/stdout_host_reader_if.sv | 25 ++
 rtl/stdout_host_reader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/stdout_host_reader_if.sv
// APB_BUS: minimal APB3 bus bundle with master and slave views.
// Widths are set per instance; the slave reads them through the instance.
interface APB_BUS #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport Master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport Slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/stdout_host_reader.sv
// stdout_host_reader: drains a first-word-fall-through stdout FIFO one word
// at a time into a holding register that the host reads over APB. Also keeps
// a sticky overflow flag, a saturating drop counter and a level interrupt.
module stdout_host_reader #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    APB_BUS.Slave       apb,
    input  logic [31:0] fifo_dout_i,
    input  logic        fifo_valid_i,
    output logic        fifo_rd_en_o,
    input  logic        fifo_overflow_i,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REG_DATA     = 2'd0,
        REG_STATUS   = 2'd1,
        REG_DROP_CNT = 2'd2,
        REG_CTRL     = 2'd3
    } reg_sel_t;

    localparam logic [7:0] CHAR_NEWLINE = 8'h0A;

    state_t                    r_state;
    logic [31:0]               r_hold;
    logic                      r_hold_vld;
    logic                      r_rd_en;
    logic                      r_line_pending;
    logic                      r_armed;
    logic                      r_ovf_sticky;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
    logic                      r_irq_en;
    logic                      r_irq;

    reg_sel_t                  w_reg_sel;
    logic                      w_access;
    logic                      w_out_of_window;
    logic                      w_err;
    logic                      w_data_rd;
    logic                      w_ctrl_wr;
    logic                      w_clear;
    logic                      w_pop;
    logic [DATA_WIDTH-1:0]     w_prdata;
    logic [31:0]               w_drop_ext;

    // APB decode: address window, register select and error classification.
    assign w_reg_sel       = reg_sel_t'(apb.paddr[3:2]);
    assign w_access        = apb.psel & apb.penable;
    assign w_out_of_window = |apb.paddr[ADDR_WIDTH-1:4];
    assign w_err           = w_out_of_window | (apb.pwrite & (w_reg_sel != REG_CTRL));
    assign w_data_rd       = w_access & ~apb.pwrite & ~w_err & (w_reg_sel == REG_DATA);
    assign w_ctrl_wr       = w_access &  apb.pwrite & ~w_err;
    assign w_clear         = w_ctrl_wr & apb.pwdata[1];
    // A DATA read only consumes the word when one is actually held.
    assign w_pop           = w_data_rd & r_hold_vld & (r_state == S_FULL);

    // Read mux: zero for writes, errors and an empty holding register.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_drop_ext                     = '0;
        w_drop_ext[DROP_CNT_WIDTH-1:0] = r_drop_cnt;
        w_prdata                       = '0;
        if (apb.psel && !apb.pwrite && !w_err) begin
            case (w_reg_sel)
                REG_DATA:     if (r_hold_vld) w_prdata = {1'b1, 7'b0, r_hold[23:0]};
                REG_STATUS:   w_prdata = {28'b0, r_line_pending, r_ovf_sticky, fifo_valid_i, r_hold_vld};
                REG_DROP_CNT: w_prdata = w_drop_ext;
                REG_CTRL:     w_prdata = {31'b0, r_irq_en};
                default:      w_prdata = '0;
            endcase
        end
    end

    assign apb.prdata  = w_prdata;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = apb.psel & w_err;

    // Fill FSM: pop one FIFO word, let the FWFT head advance, then hold it for the host.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: async reset clears every state bit, including the data word, so nothing stale leaks after reset.
        if (!rst_ni) begin
            r_state        <= S_FILL;
            r_hold         <= '0;
            r_hold_vld     <= 1'b0;
            r_rd_en        <= 1'b0;
            r_line_pending <= 1'b0;
            r_armed        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_rd_en <= 1'b0;
            // One idle edge after reset before the first pop request.
            r_armed <= 1'b1;
            case (r_state)
                S_FILL: begin
                    if (r_armed && fifo_valid_i) begin
                        r_rd_en        <= 1'b1;
                        r_hold         <= fifo_dout_i;
                        r_line_pending <= (fifo_dout_i[7:0] == CHAR_NEWLINE);
                        r_state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_hold_vld <= 1'b1;
                    r_state    <= S_FULL;
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_hold_vld     <= 1'b0;
                        r_line_pending <= 1'b0;
                        r_state        <= S_FILL;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign fifo_rd_en_o = r_rd_en;

    // Overflow tracking; a same-cycle overflow beats a clear and restarts the count at 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf_sticky <= 1'b0;
            r_drop_cnt   <= '0;
        end else if (w_clear) begin
            r_ovf_sticky <= fifo_overflow_i;
            r_drop_cnt   <= fifo_overflow_i ? DROP_CNT_WIDTH'(1) : '0;
        end else if (fifo_overflow_i) begin
            r_ovf_sticky <= 1'b1;
            if (!(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    // CTRL register: only irq_en is stored; the clear bit acts as a strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq_en <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_irq_en <= apb.pwdata[0];
        end
    end

    // Registered interrupt level, one cycle behind its causes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en & (r_hold_vld | r_ovf_sticky);
        end
    end

    assign irq_o = r_irq;

endmodule
